pwm_multi: RTL and testbench
============================

Name: pwm_multi

Overview:
- Parametrised multi-channel PWM generator. Successor to the single-channel fixed-8-bit motor PWM.
- One shared period counter with a clock prescaler drives NCH independent compare channels.
- Duty and period values are double-buffered. Changes take effect only at a period boundary, so no glitches occur.
- Sits between the control/register logic (speed setpoints) and the motor/LED driver pins.

Parameters:
- CNT_W, 8, width of the period counter, period and duty values.
- NCH, 2, number of PWM output channels (1..16).
- PRESC_W, 4, width of the prescaler divide value.
- RAMP_STEP, 1, maximum duty change per period (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- en  in  1  global run enable.
- presc  in  PRESC_W  counter advances once every presc+1 clk cycles.
- period_in  in  CNT_W  terminal count; PWM period is period_in+1 counter steps.
- duty_wr  in  1  single-cycle write strobe for one channel's duty.
- duty_ch  in  $clog2(NCH) (min 1)  channel index for the write.
- duty_val  in  CNT_W  duty value to write.
- pwm_out  out  NCH  PWM outputs, registered.
- period_tick  out  1  one-clk pulse on each counter wrap.
- busy  out  1  high while en=1 and the counter is running.

Behaviour:
- Reset, asynchronous: prescaler=0, cnt=0, shadow and active duty=0, active period=0, pwm_out=0, period_tick=0, busy=0.
- Prescaler:
  - pcnt counts 0..presc, then returns to 0.
  - step = (pcnt==presc). presc=0 gives step every clk.
- Counter:
  - On step: cnt <= (cnt==period_act) ? 0 : cnt+1.
  - Wrap = step && cnt==period_act.
  - period_tick is registered: high exactly the clk after a wrap step.
- Shadow duty:
  - duty_wr writes duty_val into shadow[duty_ch] on the next edge.
  - A duty_ch >= NCH write is ignored.
- At wrap:
  - active duty[i] <= shadow[i] for all i.
  - period_act <= period_in.
  - If duty_wr coincides with the wrap edge, active takes the pre-write shadow. The new value applies at the following wrap.
- Output compare:
  - pwm_out[i] <= en && (cnt < duty_act[i]), registered one clk after cnt.
  - duty=0 gives constantly low.
  - duty > period_act gives constantly high (100%).
  - Comparison is unsigned, full CNT_W width. No overflow term is needed.
- en=0:
  - pcnt and cnt are held at 0; pwm_out=0; busy=0.
  - Shadow registers stay writable.
- en 0->1 edge:
  - Treated as a wrap: active duty and period load from shadow/period_in on that edge.
  - Counting starts next clk.
- Period shrink: if period_in falls below the current cnt, this has no effect until the next wrap, because period_act is used. No runaway counting occurs.
- Reset mid-period: all state clears immediately, and outputs drop low asynchronously through the register reset.

Optional Feature:
- Macro PWM_MULTI_RAMP_EN.
- When defined, at each wrap active duty[i] moves toward shadow[i] by at most RAMP_STEP (saturating, no overshoot). This gives a soft start / slew limit for motors.
- On en 0->1, active duty starts from 0 and ramps up.
- When undefined, active duty loads shadow directly at wrap, and RAMP_STEP is unused.

Decomposition:
- Package pwm_pkg:
  - constants DEF_CNT_W=8 and DEF_PRESC_W=4.
  - function clog2_min1.
  - typedef pwm_ch_cfg_t {duty} for register-map reuse.
- Sub-module pwm_chan (one per channel, via generate):
  - holds shadow and active duty.
  - holds the ramp logic and the compare flop.
  - inputs: wrap, wr, val, cnt, en.
- Top pwm_multi holds the prescaler, counter and period register.

Test Plan:
- Reset/basic:
  - Stimulus: assert rst mid-run.
  - Required: pwm_out=0 and cnt=0 immediately.
  - Then release, en=1, presc=0, period_in=9, ch0 duty=3. Required: ch0 high 3 of every 10 clk, period_tick every 10 clk.
- Boundaries:
  - Stimulus: ch0 duty=0, ch1 duty=10, period_in=9.
  - Required: ch0 never high, ch1 constantly high.
  - Then ch1 duty=9. Required: ch1 low exactly 1 clk per period.
- Double-buffer:
  - Stimulus: write ch0 duty=7 mid-period, and a second write on the wrap clk.
  - Required: old duty persists to the wrap. The wrap-coincident write takes effect one period later.
- Prescaler/period change:
  - Stimulus: presc=3, period_in=4; then change period_in to 1 mid-period.
  - Required: 20-clk periods until the wrap, then 8-clk periods.
- en toggle:
  - Stimulus: en=0 for 5 clk, then en=1.
  - Required: outputs low and busy=0 while disabled. The restart loads the current shadow on the en edge, and the first high appears 1 clk later.
- Ramp (PWM_MULTI_RAMP_EN, RAMP_STEP=2):
  - Stimulus: duty 0->7.
  - Required: active duty 2,4,6,7 on successive wraps. Step 7->0 gives 5,3,1,0.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM generator.
//   DEF_CNT_W / DEF_PRESC_W : default counter and prescaler widths
//   pwm_ch_cfg_t            : per-channel register-map payload
//   clog2_min1()            : index width helper, never returns 0
package pwm_pkg;

  localparam int unsigned DEF_CNT_W   = 8;
  localparam int unsigned DEF_PRESC_W = 4;

  typedef struct packed {
    logic [DEF_CNT_W-1:0] duty;
  } pwm_ch_cfg_t;

  // Width needed to index n items; a single item still gets a 1-bit index.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pwm_chan.sv
// One PWM compare channel: shadow duty, active duty and the output flop.
// Optional macro PWM_MULTI_RAMP_EN: active duty slews toward shadow by at
// most RAMP_STEP per wrap and restarts from 0 when the block is re-enabled.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   wrap      : period boundary (includes the enable rising edge)
//   restart   : enable rising edge
//   wr, val   : shadow duty write strobe and value
//   cnt       : shared period counter
//   en        : compare enable (low forces the output low)
//   pwm       : registered PWM output
module pwm_chan
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W     = DEF_CNT_W,
  parameter int unsigned RAMP_STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wrap,
  input  logic             restart,
  input  logic             wr,
  input  logic [CNT_W-1:0] val,
  input  logic [CNT_W-1:0] cnt,
  input  logic             en,
  output logic             pwm
);

  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0] duty_q, duty_d;
  logic             pwm_q, pwm_d;

`ifdef PWM_MULTI_RAMP_EN
  localparam logic [CNT_W-1:0] STEP = CNT_W'(RAMP_STEP);
  logic [CNT_W-1:0] gap_c;
`else
  logic unused_ok;
  assign unused_ok = ^{restart, CNT_W'(RAMP_STEP)};
`endif

  // Shadow capture, active duty update at the boundary, output compare.
  always_comb begin
    shadow_d = shadow_q;
    duty_d   = duty_q;
    if (wr) shadow_d = val;
`ifdef PWM_MULTI_RAMP_EN
    gap_c = '0;
    if (restart) begin
      duty_d = '0;
    end else if (wrap) begin
      // Saturating step toward the shadow value, never overshooting it.
      if (shadow_q >= duty_q) begin
        gap_c  = shadow_q - duty_q;
        duty_d = duty_q + ((gap_c > STEP) ? STEP : gap_c);
      end else begin
        gap_c  = duty_q - shadow_q;
        duty_d = duty_q - ((gap_c > STEP) ? STEP : gap_c);
      end
    end
`else
    if (wrap) duty_d = shadow_q;
`endif
    pwm_d = en && (cnt < duty_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
      duty_q   <= '0;
      pwm_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      duty_q   <= duty_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm = pwm_q;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: shared prescaler and period counter driving
// NCH double-buffered compare channels. Duty and period changes land only on
// a period boundary. Optional macro PWM_MULTI_RAMP_EN enables duty slew
// limiting inside each channel.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   en           : global run enable
//   presc        : counter advances once every presc+1 clocks
//   period_in    : terminal count (period is period_in+1 counter steps)
//   duty_wr      : single-cycle duty write strobe
//   duty_ch      : channel index for the write (out-of-range ignored)
//   duty_val     : duty value to write
//   pwm_out      : registered PWM outputs
//   period_tick  : one-clock pulse after each counter wrap
//   busy         : high while enabled and counting
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W     = DEF_CNT_W,
  parameter int unsigned NCH       = 2,
  parameter int unsigned PRESC_W   = DEF_PRESC_W,
  parameter int unsigned RAMP_STEP = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [PRESC_W-1:0]          presc,
  input  logic [CNT_W-1:0]            period_in,
  input  logic                        duty_wr,
  input  logic [clog2_min1(NCH)-1:0]  duty_ch,
  input  logic [CNT_W-1:0]            duty_val,
  output logic [NCH-1:0]              pwm_out,
  output logic                        period_tick,
  output logic                        busy
);

  localparam int unsigned CH_W = clog2_min1(NCH);

  logic               en_q, en_d;
  logic [PRESC_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   period_act_q, period_act_d;
  logic               tick_q, tick_d;
  logic               busy_q, busy_d;

  logic en_rise_c, step_c, wrap_c, load_c, run_c;

  // Prescaler, period counter and period double-buffer.
  always_comb begin
    en_d         = en;
    pcnt_d       = pcnt_q;
    cnt_d        = cnt_q;
    period_act_d = period_act_q;
    tick_d       = 1'b0;
    busy_d       = en;

    en_rise_c = en && !en_q;
    // >= keeps the prescaler bounded if presc drops below the running count.
    step_c    = (pcnt_q >= presc);
    wrap_c    = en && !en_rise_c && step_c && (cnt_q == period_act_q);
    load_c    = wrap_c || en_rise_c;
    run_c     = en && !en_rise_c;

    if (!en) begin
      pcnt_d = '0;
      cnt_d  = '0;
    end else if (en_rise_c) begin
      // Enable edge acts as a boundary; counting starts on the next clock.
      pcnt_d       = '0;
      cnt_d        = '0;
      period_act_d = period_in;
    end else begin
      pcnt_d = step_c ? '0 : pcnt_q + 1'b1;
      if (step_c) cnt_d = wrap_c ? '0 : cnt_q + 1'b1;
      if (wrap_c) begin
        period_act_d = period_in;
        tick_d       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q         <= 1'b0;
      pcnt_q       <= '0;
      cnt_q        <= '0;
      period_act_q <= '0;
      tick_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      en_q         <= en_d;
      pcnt_q       <= pcnt_d;
      cnt_q        <= cnt_d;
      period_act_q <= period_act_d;
      tick_q       <= tick_d;
      busy_q       <= busy_d;
    end
  end

  assign period_tick = tick_q;
  assign busy        = busy_q;

  // One compare channel per output; write strobe decoded by index.
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    pwm_chan #(
      .CNT_W     (CNT_W),
      .RAMP_STEP (RAMP_STEP)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .wrap    (load_c),
      .restart (en_rise_c),
      .wr      (duty_wr && (duty_ch == CH_W'(i))),
      .val     (duty_val),
      .cnt     (cnt_q),
      .en      (run_c),
      .pwm     (pwm_out[i])
    );
  end

endmodule

// File: tb/tb_pwm_multi.sv
module tb_pwm_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] presc;
  logic [7:0] period_in;
  logic       duty_wr;
  logic [0:0] duty_ch;
  logic [7:0] duty_val;
  logic [1:0] pwm_out;
  logic       period_tick;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int len;
    int h0;
    int h1;   // -1: channel 1 not checked
  } exp_t;

  typedef struct {
    logic [3:0] presc;
    logic [7:0] per;
    logic [7:0] d0;
    logic [7:0] d1;
    int         len;
    int         h0;
    int         h1;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[7];
  int   ramp_up[4];
  int   ramp_dn[4];

  pwm_multi #(
    .CNT_W     (8),
    .NCH       (2),
    .PRESC_W   (4),
    .RAMP_STEP (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .presc       (presc),
    .period_in   (period_in),
    .duty_wr     (duty_wr),
    .duty_ch     (duty_ch),
    .duty_val    (duty_val),
    .pwm_out     (pwm_out),
    .period_tick (period_tick),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic write_duty(input int ch, input int v);
    duty_wr  = 1'b1;
    duty_ch  = 1'(ch);
    duty_val = 8'(v);
    @(posedge clk); #1;
    duty_wr  = 1'b0;
  endtask

  // Advance until a sample shows period_tick; returns edges consumed.
  task automatic wait_tick(input string name, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = 0;
    for (int i = 0; i < 5000 && !seen; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (period_tick) seen = 1'b1;
    end
    if (!seen) chk({name, "_tick_seen"}, int'(seen), 1);
  endtask

  // Starts at a tick sample; counts samples and highs up to the next tick.
  // Optionally writes ch0 duty at sample wr_at and changes period_in at per_at.
  task automatic run_period(input int wr_at, input int wr_v,
                            input int per_at, input int per_v,
                            output int len, output int h0, output int h1);
    int k;
    k = 0; h0 = 0; h1 = 0;
    do begin
      h0 += int'(pwm_out[0]);
      h1 += int'(pwm_out[1]);
      if (k == wr_at) begin
        duty_wr  = 1'b1;
        duty_ch  = 1'b0;
        duty_val = 8'(wr_v);
      end
      if (k == per_at) period_in = 8'(per_v);
      @(posedge clk); #1;
      duty_wr = 1'b0;
      k++;
    end while (!period_tick && k < 5000);
    len = k;
  endtask

  task automatic sb_check(input string name, input int len, input int h0, input int h1);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk({name, "_sb_nonempty"}, sb_q.size(), 1);
    end else begin
      e = sb_q.pop_front();
      chk({name, "_len"}, len, e.len);
      chk({name, "_high0"}, h0, e.h0);
      if (e.h1 >= 0) chk({name, "_high1"}, h1, e.h1);
    end
  endtask

  initial begin
    int c, len, h0, h1;

    vecs[0] = '{4'd0, 8'd9,   8'd0,   8'd10,  10,  0,   10};
    vecs[1] = '{4'd0, 8'd9,   8'd9,   8'd3,   10,  9,   3};
    vecs[2] = '{4'd1, 8'd4,   8'd2,   8'd5,   10,  4,   10};
    vecs[3] = '{4'd2, 8'd3,   8'd1,   8'd4,   12,  3,   12};
    vecs[4] = '{4'd0, 8'd0,   8'd1,   8'd0,   1,   1,   0};
    vecs[5] = '{4'd0, 8'd255, 8'd255, 8'd128, 256, 255, 128};
    vecs[6] = '{4'd3, 8'd4,   8'd3,   8'd0,   20,  12,  0};
    ramp_up = '{2, 4, 6, 7};
    ramp_dn = '{5, 3, 1, 0};

    rst = 1'b1; en = 1'b0; presc = '0; period_in = '0;
    duty_wr = 1'b0; duty_ch = '0; duty_val = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pwm", int'(pwm_out), 0);
    chk("reset_tick", int'(period_tick), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_cnt", int'(dut.cnt_q), 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

`ifdef PWM_MULTI_RAMP_EN
    presc = 4'd0; period_in = 8'd9; en = 1'b1;
    wait_tick("ramp_start", c);
    write_duty(0, 7);
    wait_tick("ramp_up", c);
    foreach (ramp_up[i]) begin
      sb_q.push_back('{10, ramp_up[i], -1});
      run_period(-1, 0, -1, 0, len, h0, h1);
      sb_check($sformatf("ramp_up%0d", i), len, h0, h1);
    end
    write_duty(0, 0);
    wait_tick("ramp_dn", c);
    foreach (ramp_dn[i]) begin
      sb_q.push_back('{10, ramp_dn[i], -1});
      run_period(-1, 0, -1, 0, len, h0, h1);
      sb_check($sformatf("ramp_dn%0d", i), len, h0, h1);
    end
`else
    // Basic waveform: duty 3 of 10, tick every 10 clocks.
    presc = 4'd0; period_in = 8'd9; en = 1'b1;
    write_duty(0, 3);
    write_duty(1, 0);
    wait_tick("basic", c);
    wait_tick("basic", c);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("basic_pwm0_s%0d", k), int'(pwm_out[0]), (k >= 1 && k <= 3) ? 1 : 0);
      chk($sformatf("basic_tick_s%0d", k), int'(period_tick), (k == 0) ? 1 : 0);
      @(posedge clk); #1;
    end
    chk("basic_tick_next", int'(period_tick), 1);

    // Asynchronous reset while ch0 is high.
    @(posedge clk); #1;
    chk("pre_rst_pwm0", int'(pwm_out[0]), 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_pwm", int'(pwm_out), 0);
    chk("midrst_tick", int'(period_tick), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_cnt", int'(dut.cnt_q), 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Table of steady-state configurations.
    for (int i = 0; i < 7; i++) begin
      presc     = vecs[i].presc;
      period_in = vecs[i].per;
      write_duty(0, int'(vecs[i].d0));
      write_duty(1, int'(vecs[i].d1));
      sb_q.push_back('{vecs[i].len, vecs[i].h0, vecs[i].h1});
      wait_tick("vec", c);
      wait_tick("vec", c);
      run_period(-1, 0, -1, 0, len, h0, h1);
      sb_check($sformatf("vec%0d", i), len, h0, h1);
    end

    // Double buffering: mid-period write, then a write on the wrap edge.
    presc = 4'd0; period_in = 8'd9;
    write_duty(0, 3);
    wait_tick("dbuf", c);
    wait_tick("dbuf", c);
    sb_q.push_back('{10, 3, -1});
    run_period(4, 7, -1, 0, len, h0, h1);
    sb_check("dbuf_mid", len, h0, h1);
    sb_q.push_back('{10, 7, -1});
    run_period(9, 2, -1, 0, len, h0, h1);
    sb_check("dbuf_wrapwr", len, h0, h1);
    sb_q.push_back('{10, 7, -1});
    run_period(-1, 0, -1, 0, len, h0, h1);
    sb_check("dbuf_hold", len, h0, h1);
    sb_q.push_back('{10, 2, -1});
    run_period(-1, 0, -1, 0, len, h0, h1);
    sb_check("dbuf_new", len, h0, h1);

    // Prescaler 3, period 4 -> 20 clocks; shrink to period 1 while cnt=3.
    presc = 4'd3; period_in = 8'd4;
    write_duty(0, 3);
    wait_tick("presc", c);
    wait_tick("presc", c);
    sb_q.push_back('{20, 12, -1});
    run_period(-1, 0, -1, 0, len, h0, h1);
    sb_check("presc_base", len, h0, h1);
    sb_q.push_back('{20, 12, -1});
    run_period(-1, 0, 12, 1, len, h0, h1);
    sb_check("presc_shrink", len, h0, h1);
    // First short period's sample 0 still reflects cnt=4 (low).
    sb_q.push_back('{8, 7, -1});
    run_period(-1, 0, -1, 0, len, h0, h1);
    sb_check("presc_first_short", len, h0, h1);
    sb_q.push_back('{8, 8, -1});
    run_period(-1, 0, -1, 0, len, h0, h1);
    sb_check("presc_short", len, h0, h1);

    // Disable for 5 clocks, reprogram, re-enable.
    en = 1'b0; presc = 4'd0; period_in = 8'd9;
    write_duty(0, 5);
    chk("dis_pwm_0", int'(pwm_out), 0);
    chk("dis_busy_0", int'(busy), 0);
    for (int k = 1; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("dis_pwm_%0d", k), int'(pwm_out), 0);
      chk($sformatf("dis_busy_%0d", k), int'(busy), 0);
    end
    en = 1'b1;
    @(posedge clk); #1;
    chk("en_edge_pwm0", int'(pwm_out[0]), 0);
    chk("en_edge_busy", int'(busy), 1);
    @(posedge clk); #1;
    chk("en_first_high", int'(pwm_out[0]), 1);
    wait_tick("en_restart", c);
    chk("en_first_period", c, 9);
    sb_q.push_back('{10, 5, -1});
    run_period(-1, 0, -1, 0, len, h0, h1);
    sb_check("en_steady", len, h0, h1);
`endif

    chk("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
